// File: rtl/delay_timer_arbiter_pkg.sv
// Shared types and defaults for the delay timer arbiter.
// Imported by the interface, the arbiter and the top.
package delay_timer_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/delay_timer_arbiter_if.sv
// Requester-side bus of the delay timer arbiter.
// Master drives requests, slave is the timer.
interface delay_timer_arbiter_if
    import delay_timer_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int IW = idx_w(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] len;
    logic                   abort;
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [IW-1:0]          owner;
    logic [WIDTH-1:0]       cnt_q;

    modport master (
        output req, len, abort,
        input  ack, done, busy, owner, cnt_q
    );

    modport slave (
        input  req, len, abort,
        output ack, done, busy, owner, cnt_q
    );

endinterface

// File: rtl/delay_timer_arbiter_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// Search starts one position after ptr and wraps.
module rr_arbiter
    import delay_timer_arbiter_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + i) % N] = 1'b1;
                idx = IW'((int'(ptr) + i) % N);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_timer_arbiter.sv
// One down-counting delay timer shared round-robin among requesters.
// ack is issued in IDLE, done when the owner's count reaches zero.
module delay_timer_arbiter
    import delay_timer_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    delay_timer_arbiter_if.slave bus
);

    localparam int IW = idx_w(N_REQ);

    state_e           state;
    logic [WIDTH-1:0] cnt;
    logic [IW-1:0]    own;
    logic [IW-1:0]    ptr;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gidx;
    logic             gany;
    logic [WIDTH-1:0] len_sel;
    logic [N_REQ-1:0] own_oh;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req (bus.req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    assign len_sel = bus.len[int'(gidx)*WIDTH +: WIDTH];
    assign own_oh  = N_REQ'(1) << own;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            own   <= '0;
            ptr   <= IW'(N_REQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (gany) begin
                        cnt   <= len_sel;
                        own   <= gidx;
                        ptr   <= gidx;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    // Expiry outranks abort; abort freezes the count.
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else if (bus.abort) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates ack since a held request would otherwise show through.
    assign bus.ack   = (state == IDLE && !rst) ? gnt : '0;
    assign bus.done  = (state == COUNT && cnt == '0) ? own_oh : '0;
    assign bus.busy  = (state == COUNT);
    assign bus.owner = own;
    assign bus.cnt_q = cnt;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed self-checking bench for delay_timer_arbiter.
module tb_delay_timer_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    delay_timer_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    delay_timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_len(input int i, input logic [W-1:0] v);
        bus.len[i*W +: W] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_len(0, 32'd20);
        bus.req = 4'b0001;
        #1;
        tests++;
        if (bus.ack !== 4'b0001) begin
            fails++;
            $display("FAIL rst_pre_ack got %b exp %b", bus.ack, 4'b0001);
        end
        cyc();
        bus.req = 4'b0000;
        repeat (3) cyc();
        #1;
        tests++;
        if (bus.busy !== 1'b1 || bus.cnt_q !== 32'd17) begin
            fails++;
            $display("FAIL rst_mid busy=%b cnt=%0d exp 1/17", bus.busy, bus.cnt_q);
        end
        bus.req = 4'b0100;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 4'b0 || bus.ack !== 4'b0) begin
            fails++;
            $display("FAIL rst_async busy=%b done=%b ack=%b exp 0", bus.busy, bus.done, bus.ack);
        end
        tests++;
        if (bus.cnt_q !== 32'd0 || bus.owner !== 2'd0) begin
            fails++;
            $display("FAIL rst_async_regs cnt=%0d owner=%0d exp 0/0", bus.cnt_q, bus.owner);
        end
        cyc();
        bus.req = 4'b0000;
        rst = 1'b0;
        cyc();
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.ack !== 4'b0 || bus.done !== 4'b0) begin
            fails++;
            $display("FAIL rst_idle busy=%b ack=%b done=%b exp 0", bus.busy, bus.ack, bus.done);
        end
    endtask

    task automatic test_single();
        set_len(0, 32'd5);
        bus.req = 4'b0001;
        #1;
        tests++;
        if (bus.ack !== 4'b0001 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL single_ack ack=%b busy=%b exp 0001/0", bus.ack, bus.busy);
        end
        cyc();
        bus.req = 4'b0000;
        for (int k = 5; k >= 0; k--) begin
            #1;
            tests++;
            if (bus.cnt_q !== W'(k) || bus.busy !== 1'b1 || bus.done !== ((k == 0) ? 4'b0001 : 4'b0000)) begin
                fails++;
                $display("FAIL single_cnt%0d cnt=%0d busy=%b done=%b", k, bus.cnt_q, bus.busy, bus.done);
            end
            cyc();
        end
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 4'b0 || bus.cnt_q !== 32'd0) begin
            fails++;
            $display("FAIL single_end busy=%b done=%b cnt=%0d exp 0", bus.busy, bus.done, bus.cnt_q);
        end
    endtask

    task automatic test_zero_len();
        set_len(1, 32'd0);
        bus.req = 4'b0010;
        #1;
        tests++;
        if (bus.ack !== 4'b0010) begin
            fails++;
            $display("FAIL zero_ack got %b exp 0010", bus.ack);
        end
        cyc();
        bus.req = 4'b0000;
        #1;
        tests++;
        if (bus.done !== 4'b0010 || bus.owner !== 2'd1 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL zero_done done=%b owner=%0d busy=%b exp 0010/1/1", bus.done, bus.owner, bus.busy);
        end
        cyc();
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 4'b0) begin
            fails++;
            $display("FAIL zero_end busy=%b done=%b exp 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, 32'd2);
        bus.req = 4'b1111;
        for (int g = 0; g < N; g++) begin
            #1;
            tests++;
            if (bus.ack !== (4'b0001 << g)) begin
                fails++;
                $display("FAIL b2b_ack%0d got %b exp %b", g, bus.ack, 4'b0001 << g);
            end
            cyc();
            bus.req[g] = 1'b0;
            for (int k = 0; k <= 2; k++) begin
                #1;
                tests++;
                if (bus.ack !== 4'b0 || bus.done !== ((k == 2) ? (4'b0001 << g) : 4'b0000)) begin
                    fails++;
                    $display("FAIL b2b_run%0d_%0d ack=%b done=%b", g, k, bus.ack, bus.done);
                end
                cyc();
            end
        end
        #1;
        tests++;
        if (bus.ack !== 4'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end ack=%b busy=%b exp 0", bus.ack, bus.busy);
        end
    endtask

    task automatic test_abort();
        set_len(2, 32'd10);
        set_len(3, 32'd4);
        bus.req = 4'b0100;
        #1;
        tests++;
        if (bus.ack !== 4'b0100) begin
            fails++;
            $display("FAIL abort_ack got %b exp 0100", bus.ack);
        end
        cyc();
        bus.req = 4'b1000;
        repeat (7) cyc();
        #1;
        tests++;
        if (bus.cnt_q !== 32'd3 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre cnt=%0d busy=%b exp 3/1", bus.cnt_q, bus.busy);
        end
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 4'b0 || bus.cnt_q !== 32'd3) begin
            fails++;
            $display("FAIL abort_stop busy=%b done=%b cnt=%0d exp 0/0000/3", bus.busy, bus.done, bus.cnt_q);
        end
        tests++;
        if (bus.ack !== 4'b1000) begin
            fails++;
            $display("FAIL abort_next_ack got %b exp 1000", bus.ack);
        end
        cyc();
        bus.req = 4'b0000;
        #1;
        tests++;
        if (bus.cnt_q !== 32'd4 || bus.owner !== 2'd3) begin
            fails++;
            $display("FAIL abort_reload cnt=%0d owner=%0d exp 4/3", bus.cnt_q, bus.owner);
        end
        repeat (4) cyc();
        #1;
        tests++;
        if (bus.done !== 4'b1000) begin
            fails++;
            $display("FAIL abort_done3 got %b exp 1000", bus.done);
        end
        cyc();
    endtask

    task automatic test_abort_done_fair();
        set_len(0, 32'd1);
        bus.req = 4'b0001;
        #1;
        tests++;
        if (bus.ack !== 4'b0001) begin
            fails++;
            $display("FAIL ad_ack got %b exp 0001", bus.ack);
        end
        cyc();
        bus.req = 4'b0000;
        cyc();
        bus.abort = 1'b1;
        #1;
        tests++;
        if (bus.done !== 4'b0001) begin
            fails++;
            $display("FAIL ad_done got %b exp 0001", bus.done);
        end
        cyc();
        set_len(3, 32'd0);
        bus.req = 4'b1000;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.ack !== 4'b1000) begin
            fails++;
            $display("FAIL ad_idle_abort busy=%b ack=%b exp 0/1000", bus.busy, bus.ack);
        end
        cyc();
        bus.abort = 1'b0;
        bus.req = 4'b0000;
        #1;
        tests++;
        if (bus.done !== 4'b1000 || bus.owner !== 2'd3) begin
            fails++;
            $display("FAIL fair_g3 done=%b owner=%0d exp 1000/3", bus.done, bus.owner);
        end
        cyc();
        set_len(0, 32'd0);
        bus.req = 4'b1001;
        #1;
        tests++;
        if (bus.ack !== 4'b0001) begin
            fails++;
            $display("FAIL fair_pick0 got %b exp 0001", bus.ack);
        end
        cyc();
        bus.req = 4'b1000;
        #1;
        tests++;
        if (bus.done !== 4'b0001) begin
            fails++;
            $display("FAIL fair_done0 got %b exp 0001", bus.done);
        end
        cyc();
        #1;
        tests++;
        if (bus.ack !== 4'b1000) begin
            fails++;
            $display("FAIL fair_rearb3 got %b exp 1000", bus.ack);
        end
        cyc();
        bus.req = 4'b0000;
        cyc();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.len = '0;
        bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        test_reset();
        test_single();
        test_zero_len();
        test_back_to_back();
        test_abort();
        test_abort_done_fair();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
